// File: rtl/add_or_multiply_pkg.sv
// Shared constants for the add_or_multiply datapath: default widths and
// the encoding of the operation select.
package add_or_multiply_pkg;

   localparam int IN_W_DEF  = 4;
   localparam int OUT_W_DEF = 8;

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_MUL = 1'b1;

endpackage : add_or_multiply_pkg

// File: rtl/add_or_multiply_multiplier.sv
// Purely combinational IN_W x IN_W unsigned array multiplier built from
// explicit shifted partial products that are summed into a 2*IN_W result.
module shift_add_multiplier #(
   parameter int IN_W = 4
) (
   input  logic [IN_W-1:0]   input1,
   input  logic [IN_W-1:0]   input2,
   output logic [2*IN_W-1:0] product
);

   localparam int PW = 2 * IN_W;

   logic [PW-1:0] w_pp [IN_W];
   logic [PW-1:0] w_sum;

   // Row i is operand A gated by bit i of operand B, weighted by 2^i.
   for (genvar gi = 0; gi < IN_W; gi++) begin : g_pp
      assign w_pp[gi] = {{IN_W{1'b0}}, input1 & {IN_W{input2[gi]}}} << gi;
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < IN_W; i++) begin
         w_sum = w_sum + w_pp[i];
      end
   end

   assign product = w_sum;

endmodule : shift_add_multiplier

// File: rtl/add_or_multiply.sv
// Registered add/multiply selector: both paths are evaluated every cycle,
// a 2:1 mux picks one, and a single output register holds the result.
module add_or_multiply
   import add_or_multiply_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic             sel,
   input  logic [IN_W-1:0]  input1,
   input  logic [IN_W-1:0]  input2,
   output logic [OUT_W-1:0] selected
);

   logic [2*IN_W-1:0] w_product;
   logic [OUT_W-1:0]  w_product_ext;
   logic [OUT_W-1:0]  w_sum;
   logic [OUT_W-1:0]  w_next;
   logic [OUT_W-1:0]  r_selected;

   shift_add_multiplier #(
      .IN_W (IN_W)
   ) u_mult (
      .input1  (input1),
      .input2  (input2),
      .product (w_product)
   );

   // Summing at OUT_W width keeps the carry out of the operand width.
   assign w_sum         = OUT_W'(input1) + OUT_W'(input2);
   assign w_product_ext = OUT_W'(w_product);
   assign w_next        = (sel == SEL_MUL) ? w_product_ext : w_sum;

   // reset_n is active-high despite its name.
   always_ff @(posedge clk_i) begin
      if (reset_n) begin
         r_selected <= '0;
      end else begin
         r_selected <= w_next;
      end
   end

   assign selected = r_selected;

endmodule : add_or_multiply

// File: tb/tb_add_or_multiply.sv
// Directed and exhaustive checks of add_or_multiply with hand-computed
// expectations and one-cycle latency.
module tb_add_or_multiply;

   logic       clk_i;
   logic       reset_n;
   logic       sel;
   logic [3:0] input1;
   logic [3:0] input2;
   logic [7:0] selected;

   int n_checks;
   int n_pass;
   int n_fail;

   add_or_multiply dut (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .sel      (sel),
      .input1   (input1),
      .input2   (input2),
      .selected (selected)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic apply(input logic rst, input logic s, input logic [3:0] a,
                        input logic [3:0] b);
      reset_n = rst;
      sel     = s;
      input1  = a;
      input2  = b;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      n_checks++;
      assert (selected === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, selected, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_v;
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      reset_n  = 1'b1;
      sel      = 1'b0;
      input1   = 4'd5;
      input2   = 4'd3;

      // Reset with live operands
      apply(1'b1, 1'b0, 4'd5, 4'd3);  check("reset_state", 8'd0);
      apply(1'b0, 1'b0, 4'd5, 4'd3);  check("first_add", 8'd8);

      // Add then multiply
      apply(1'b0, 1'b1, 4'd5, 4'd3);  check("mul_5_3", 8'd15);

      // Operand change between edges must not reach the output
      input1 = 4'd4;
      input2 = 4'd7;
      #3;
      check("no_comb_path", 8'd15);
      apply(1'b0, 1'b1, 4'd4, 4'd7);  check("mul_4_7", 8'd28);
      apply(1'b0, 1'b0, 4'd4, 4'd7);  check("add_4_7", 8'd11);
      apply(1'b0, 1'b1, 4'd4, 4'd7);  check("mul_4_7_again", 8'd28);

      // Simultaneous change of op and operands
      apply(1'b0, 1'b0, 4'd9, 4'd2);  check("switch_both", 8'd11);

      // Extremes
      apply(1'b0, 1'b0, 4'd15, 4'd15); check("add_15_15", 8'd30);
      apply(1'b0, 1'b1, 4'd15, 4'd15); check("mul_15_15", 8'd225);
      apply(1'b0, 1'b1, 4'd0, 4'd15);  check("mul_0_15", 8'd0);
      apply(1'b0, 1'b0, 4'd0, 4'd15);  check("add_0_15", 8'd15);
      apply(1'b0, 1'b1, 4'd1, 4'd15);  check("mul_1_15", 8'd15);

      // Reset mid-stream
      apply(1'b0, 1'b1, 4'd4, 4'd7);  check("pre_reset_mul", 8'd28);
      apply(1'b1, 1'b1, 4'd4, 4'd7);  check("mid_reset", 8'd0);
      apply(1'b0, 1'b1, 4'd4, 4'd7);  check("post_reset_mul", 8'd28);

      // Exhaustive sweep against a reference model
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               apply(1'b0, s[0], a[3:0], b[3:0]);
               exp_v = (s == 1) ? 8'(a * b) : 8'(a + b);
               check($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), exp_v);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_add_or_multiply
